// File: rtl/rob_alloc_ctrl.sv
// ROB allocation controller: packs valid submit lanes into consecutive ROB slots,
// tracks head/tail/occupancy and blocks rename during post-flush recovery.
// Optional macro ROB_ALLOC_CMT_BYPASS_EN lets same-cycle commits free room for allocation.
module rob_alloc_ctrl #(
  parameter int unsigned WIDTH          = 3,
  parameter int unsigned DEPTH          = 32,
  parameter int unsigned RECOVER_CYCLES = 2
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic [WIDTH-1:0]                      sub_valid,
  output logic                                  sub_ready,
  output logic [WIDTH-1:0]                      alloc_en,
  output logic [WIDTH-1:0][$clog2(DEPTH)-1:0]   alloc_idx,
  input  logic [$clog2(WIDTH+1)-1:0]            cmt_count,
  input  logic                                  flush,
  output logic [$clog2(DEPTH)-1:0]              head_idx,
  output logic [$clog2(DEPTH)-1:0]              tail_idx,
  output logic [$clog2(DEPTH+1)-1:0]            count,
  output logic                                  empty,
  output logic                                  full
);

  localparam int unsigned IW  = $clog2(DEPTH);
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned NW  = $clog2(WIDTH + 1);
  localparam int unsigned CXW = CW + 1;
  localparam int unsigned RW  = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   rcnt_q, rcnt_d;
  logic [IW-1:0]   head_q, head_d;
  logic [IW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [NW-1:0]   acc;
  logic [NW-1:0]   nalloc;
  logic [CXW-1:0]  room;

  // State, recovery counter and pointer registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      rcnt_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Slot assignment, acceptance and next-state computation
  always_comb begin
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    sub_ready = 1'b0;
    nalloc    = '0;
    acc       = '0;
    alloc_idx = '0;

`ifdef ROB_ALLOC_CMT_BYPASS_EN
    room = CXW'(DEPTH) - CXW'(count_q) + CXW'(cmt_count);
`else
    room = CXW'(DEPTH) - CXW'(count_q);
`endif

    // Prefix popcount packs sparse valid lanes into consecutive slots
    for (int i = 0; i < int'(WIDTH); i++) begin
      alloc_idx[i] = tail_q + IW'(acc);
      acc          = acc + NW'(sub_valid[i]);
    end

    case (state_q)
      RUN: begin
        sub_ready = (room >= CXW'(WIDTH)) && !flush;
        nalloc    = sub_ready ? acc : '0;
        head_d    = head_q + IW'(cmt_count);
        tail_d    = tail_q + IW'(nalloc);
        count_d   = count_q + CW'(nalloc) - CW'(cmt_count);
      end
      RECOVER: begin
        if (rcnt_q == '0) state_d = RUN;
        else              rcnt_d  = rcnt_q - RW'(1);
      end
      default: state_d = RUN;
    endcase

    // Flush squashes everything behind the post-commit head
    if (flush) begin
      tail_d  = head_d;
      count_d = '0;
      state_d = RECOVER;
      rcnt_d  = RW'(RECOVER_CYCLES - 1);
    end
  end

  assign alloc_en = sub_valid & {WIDTH{sub_ready}};
  assign head_idx = head_q;
  assign tail_idx = tail_q;
  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q > CW'(DEPTH - WIDTH));

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Directed self-checking bench for rob_alloc_ctrl with hand-computed expectations.
module tb_rob_alloc_ctrl;

  localparam int unsigned WIDTH = 3;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned IW    = 5;
  localparam int unsigned CW    = 6;
  localparam int unsigned NW    = 2;

  logic                       clock = 1'b0;
  logic                       reset_n;
  logic [WIDTH-1:0]           sub_valid;
  logic                       sub_ready;
  logic [WIDTH-1:0]           alloc_en;
  logic [WIDTH-1:0][IW-1:0]   alloc_idx;
  logic [NW-1:0]              cmt_count;
  logic                       flush;
  logic [IW-1:0]              head_idx;
  logic [IW-1:0]              tail_idx;
  logic [CW-1:0]              count;
  logic                       empty;
  logic                       full;

  int checks = 0;
  int errors = 0;

  rob_alloc_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RECOVER_CYCLES(2)) dut (
    .clock(clock), .reset_n(reset_n), .sub_valid(sub_valid), .sub_ready(sub_ready),
    .alloc_en(alloc_en), .alloc_idx(alloc_idx), .cmt_count(cmt_count), .flush(flush),
    .head_idx(head_idx), .tail_idx(tail_idx), .count(count), .empty(empty), .full(full)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; sub_valid = '0; cmt_count = '0; flush = 1'b0;
    #2;
    @(negedge clock);
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; sub_valid = '0; cmt_count = '0; flush = 1'b0;
    #1;
    checks++; if (sub_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", sub_ready); end
    checks++; if (alloc_en !== 3'b000) begin errors++; $display("FAIL rst_alloc_en got %b exp 000", alloc_en); end
    checks++; if (head_idx !== 5'd0 || tail_idx !== 5'd0) begin errors++; $display("FAIL rst_ptrs got %0d/%0d exp 0/0", head_idx, tail_idx); end
    checks++; if (count !== 6'd0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL rst_occ got %0d/%b/%b exp 0/1/0", count, empty, full); end
    @(negedge clock);
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_alloc_seq();
    for (int k = 0; k < 4; k++) begin
      sub_valid = 3'b111;
      #1;
      checks++; if (alloc_en !== 3'b111) begin errors++; $display("FAIL seq_en[%0d] got %b exp 111", k, alloc_en); end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (alloc_idx[i] !== IW'(3*k + i)) begin errors++; $display("FAIL seq_idx[%0d][%0d] got %0d exp %0d", k, i, alloc_idx[i], 3*k + i); end
      end
      step();
    end
    sub_valid = '0;
    #1;
    checks++; if (count !== 6'd12 || tail_idx !== 5'd12 || head_idx !== 5'd0) begin errors++; $display("FAIL seq_state got c%0d t%0d h%0d exp 12/12/0", count, tail_idx, head_idx); end
    checks++; if (empty !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL seq_flags got e%b f%b exp 0/0", empty, full); end
  endtask

  task automatic test_full_wrap();
    logic exp_bypass_ready;
`ifdef ROB_ALLOC_CMT_BYPASS_EN
    exp_bypass_ready = 1'b1;
`else
    exp_bypass_ready = 1'b0;
`endif
    for (int k = 0; k < 6; k++) begin
      sub_valid = 3'b111;
      step();
    end
    #1;
    checks++; if (sub_ready !== 1'b0 || full !== 1'b1 || alloc_en !== 3'b000) begin errors++; $display("FAIL full_block got r%b f%b en%b exp 0/1/000", sub_ready, full, alloc_en); end
    step();
    checks++; if (count !== 6'd30 || tail_idx !== 5'd30) begin errors++; $display("FAIL full_hold got c%0d t%0d exp 30/30", count, tail_idx); end
    cmt_count = 2'd1;
    #1;
    checks++; if (sub_ready !== exp_bypass_ready) begin errors++; $display("FAIL full_cmt_ready got %b exp %b", sub_ready, exp_bypass_ready); end
    sub_valid = '0;
    step();
    checks++; if (count !== 6'd29 || head_idx !== 5'd1) begin errors++; $display("FAIL full_commit got c%0d h%0d exp 29/1", count, head_idx); end
    cmt_count = '0;
    sub_valid = 3'b101;
    #1;
    checks++; if (sub_ready !== 1'b1 || alloc_en !== 3'b101) begin errors++; $display("FAIL wrap_en got r%b en%b exp 1/101", sub_ready, alloc_en); end
    checks++; if (alloc_idx[0] !== 5'd30 || alloc_idx[2] !== 5'd31) begin errors++; $display("FAIL wrap_idx got %0d/%0d exp 30/31", alloc_idx[0], alloc_idx[2]); end
    step();
    sub_valid = '0;
    checks++; if (tail_idx !== 5'd0 || count !== 6'd31) begin errors++; $display("FAIL wrap_tail got t%0d c%0d exp 0/31", tail_idx, count); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      sub_valid = 3'b111;
      step();
    end
    sub_valid = 3'b011; cmt_count = 2'd3;
    #1;
    checks++; if (alloc_en !== 3'b011 || alloc_idx[0] !== 5'd12 || alloc_idx[1] !== 5'd13) begin errors++; $display("FAIL part_idx got en%b %0d/%0d exp 011 12/13", alloc_en, alloc_idx[0], alloc_idx[1]); end
    step();
    sub_valid = '0; cmt_count = 2'd2;
    step();
    checks++; if (head_idx !== 5'd5 || count !== 6'd9 || tail_idx !== 5'd14) begin errors++; $display("FAIL pre_flush got h%0d c%0d t%0d exp 5/9/14", head_idx, count, tail_idx); end
    sub_valid = 3'b111; cmt_count = 2'd2; flush = 1'b1;
    #1;
    checks++; if (sub_ready !== 1'b0 || alloc_en !== 3'b000) begin errors++; $display("FAIL flush_cycle got r%b en%b exp 0/000", sub_ready, alloc_en); end
    step();
    flush = 1'b0; cmt_count = '0;
    #1;
    checks++; if (head_idx !== 5'd7 || tail_idx !== 5'd7 || count !== 6'd0 || empty !== 1'b1) begin errors++; $display("FAIL flush_state got h%0d t%0d c%0d e%b exp 7/7/0/1", head_idx, tail_idx, count, empty); end
    for (int k = 1; k <= 2; k++) begin
      checks++; if (sub_ready !== 1'b0) begin errors++; $display("FAIL recover_ready[%0d] got %b exp 0", k, sub_ready); end
      step();
    end
    checks++; if (sub_ready !== 1'b1 || alloc_idx[0] !== 5'd7 || alloc_idx[2] !== 5'd9) begin errors++; $display("FAIL recover_done got r%b %0d/%0d exp 1 7/9", sub_ready, alloc_idx[0], alloc_idx[2]); end
    sub_valid = '0;
    step();
  endtask

  task automatic test_reflush();
    flush = 1'b1;
    step();
    flush = 1'b1;
    #1;
    checks++; if (sub_ready !== 1'b0) begin errors++; $display("FAIL reflush_cycle got %b exp 0", sub_ready); end
    step();
    flush = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      #1;
      checks++; if (sub_ready !== 1'b0) begin errors++; $display("FAIL reflush_recover[%0d] got %b exp 0", k, sub_ready); end
      step();
    end
    checks++; if (sub_ready !== 1'b1 || tail_idx !== 5'd7) begin errors++; $display("FAIL reflush_done got r%b t%0d exp 1/7", sub_ready, tail_idx); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 5; k++) begin
      sub_valid = 3'b111;
      step();
    end
    sub_valid = 3'b011;
    step();
    sub_valid = 3'b111;
    #1;
    checks++; if (count !== 6'd17 || alloc_idx[0] !== 5'd24) begin errors++; $display("FAIL mid_pre got c%0d i%0d exp 17/24", count, alloc_idx[0]); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (count !== 6'd0 || head_idx !== 5'd0 || tail_idx !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL mid_rst got c%0d h%0d t%0d e%b f%b exp 0/0/0/1/0", count, head_idx, tail_idx, empty, full); end
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    checks++; if (sub_ready !== 1'b1 || alloc_idx[0] !== 5'd0 || alloc_idx[1] !== 5'd1 || alloc_idx[2] !== 5'd2) begin errors++; $display("FAIL mid_idx got r%b %0d/%0d/%0d exp 1 0/1/2", sub_ready, alloc_idx[0], alloc_idx[1], alloc_idx[2]); end
    step();
    sub_valid = '0;
    checks++; if (tail_idx !== 5'd3 || count !== 6'd3) begin errors++; $display("FAIL mid_accept got t%0d c%0d exp 3/3", tail_idx, count); end
  endtask

  initial begin
    test_reset();
    test_alloc_seq();
    test_full_wrap();
    test_flush();
    test_reflush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
